// File: rtl/io_uart_tx.sv
// io_uart_tx -- memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// Software pushes bytes through the TXDATA register into a FIFO. A baud
// state machine pops them and shifts them out on txd as start bit, 8 data
// bits LSB first and one stop bit, each lasting DIV clocks. Frames run back
// to back with no idle gap while bytes remain and tx_en is set.
//
// Register map (ioAddr[3:2]):
//   0 TXDATA  write pushes ioWtData[7:0], reads 0
//   1 STATUS  {count[7:4], overrun[3], empty[2], full[1], busy[0]},
//             writing 1 to bit3 clears overrun
//   2 CTRL    {irq_en[1], tx_en[0]}
//   3 DIV     clocks per bit [15:0]
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-low reset
//   ioCe     I/O access enable
//   ioWe     write strobe, qualified by ioCe
//   ioAddr   byte address, only [3:2] decoded
//   ioWtData write data
//   ioRdData combinational read data, 0 when ioCe is low
//   txd      serial output, idles high
//   intr     registered level interrupt: irq_en & empty & ~busy
module io_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ioCe,
  input  logic        ioWe,
  input  logic [31:0] ioAddr,
  input  logic [31:0] ioWtData,
  output logic [31:0] ioRdData,
  output logic        txd,
  output logic        intr
);

  localparam int         PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DEPTH_CNT = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txStateT;

  txStateT          state, stateNext;
  logic [15:0]      cnt;
  logic [15:0]      activeDiv;
  logic [2:0]       bitIdx;
  logic [7:0]       shiftReg;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [3:0]       count;
  logic             overrun;
  logic             txEn, irqEn;
  logic [15:0]      divReg;

  logic       wrEn, push, pushFull, ovrClr;
  logic       doPop, bitEnd, busy, empty, full, canPop;
  logic [1:0] regSel;
  logic       unusedBits;

  assign unusedBits = ^{ioAddr[31:4], ioAddr[1:0], ioWtData[31:16]};

  assign regSel   = ioAddr[3:2];
  assign wrEn     = ioCe & ioWe;
  assign empty    = (count == 4'd0);
  assign full     = (count == DEPTH_CNT);
  assign busy     = (state != IDLE);
  // Fullness is judged on the pre-edge count, so a same-cycle pop never
  // rescues a push into a full FIFO.
  assign push     = wrEn && (regSel == 2'd0) && !full;
  assign pushFull = wrEn && (regSel == 2'd0) && full;
  assign ovrClr   = wrEn && (regSel == 2'd1) && ioWtData[3];
  assign canPop   = txEn && !empty;
  assign bitEnd   = (cnt == activeDiv - 16'd1);

  // Read mux
  always_comb begin
    ioRdData = 32'd0;
    if (ioCe) begin
      case (regSel)
        2'd1:    ioRdData = {24'd0, count, overrun, empty, full, busy};
        2'd2:    ioRdData = {30'd0, irqEn, txEn};
        2'd3:    ioRdData = {16'd0, divReg};
        default: ioRdData = 32'd0;
      endcase
    end
  end

  // Register file
  always_ff @(posedge clk) begin
    if (!rst) begin
      txEn    <= 1'b1;
      irqEn   <= 1'b0;
      divReg  <= 16'(CLK_DIV);
      overrun <= 1'b0;
      intr    <= 1'b0;
    end else begin
      if (wrEn && regSel == 2'd2) begin
        txEn  <= ioWtData[0];
        irqEn <= ioWtData[1];
      end
      if (wrEn && regSel == 2'd3) divReg <= ioWtData[15:0];
      // Set has priority over clear.
      if (pushFull)    overrun <= 1'b1;
      else if (ovrClr) overrun <= 1'b0;
      intr <= irqEn & empty & ~busy;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= 4'd0;
    end else begin
      if (push)  wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      case ({push, doPop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= ioWtData[7:0];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // FSM next state, pop request and serial output
  always_comb begin
    stateNext = state;
    doPop     = 1'b0;
    txd       = 1'b1;
    case (state)
      IDLE: begin
        if (canPop) begin
          doPop     = 1'b1;
          stateNext = START;
        end
      end
      START: begin
        txd = 1'b0;
        if (bitEnd) stateNext = DATA;
      end
      DATA: begin
        txd = shiftReg[0];
        if (bitEnd && bitIdx == 3'd7) stateNext = STOP;
      end
      STOP: begin
        if (bitEnd) begin
          // Chain straight into the next start bit when more data waits.
          if (canPop) begin
            doPop     = 1'b1;
            stateNext = START;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bit timing counters; divisor is frozen per frame at the pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= 16'd0;
      bitIdx    <= 3'd0;
      activeDiv <= 16'd1;
    end else if (doPop) begin
      cnt       <= 16'd0;
      bitIdx    <= 3'd0;
      activeDiv <= (divReg == 16'd0) ? 16'd1 : divReg;
    end else if (state != IDLE) begin
      if (bitEnd) begin
        cnt <= 16'd0;
        if (state == DATA) bitIdx <= bitIdx + 3'd1;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doPop)                      shiftReg <= mem[rdPtr];
    else if (state == DATA && bitEnd) shiftReg <= shiftReg >> 1;
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed-plus-random bench for io_uart_tx. Expected txd waveforms are
// derived from the byte sequence with plain frame arithmetic (start bit,
// 8 data bits LSB first, stop bit, div clocks each).
module tb_io_uart_tx;

  localparam int FIFO_DEPTH = 8;
  localparam int CLK_DIV    = 434;

  logic        clk = 1'b0;
  logic        rst;
  logic        ioCe, ioWe;
  logic [31:0] ioAddr, ioWtData;
  logic [31:0] ioRdData;
  logic        txd, intr;

  int total = 0;
  int bad   = 0;
  logic [7:0] expQ [$];

  io_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .ioCe(ioCe), .ioWe(ioWe), .ioAddr(ioAddr),
    .ioWtData(ioWtData), .ioRdData(ioRdData), .txd(txd), .intr(intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic busWrite(input int idx, input logic [31:0] d);
    logic [31:0] a;
    a = $urandom();
    a[3:2] = 2'(idx);
    ioAddr = a; ioWtData = d; ioCe = 1'b1; ioWe = 1'b1;
    @(negedge clk);
    ioCe = 1'b0; ioWe = 1'b0;
  endtask

  task automatic busRead(input int idx, output logic [31:0] rd);
    logic [31:0] a;
    a = $urandom();
    a[3:2] = 2'(idx);
    ioAddr = a; ioCe = 1'b1; ioWe = 1'b0;
    #1;
    rd = ioRdData;
    ioCe = 1'b0;
  endtask

  function automatic logic frameBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return d[idx-1];
  endfunction

  function automatic logic [31:0] statusWord(input int cnt, input bit ovr, input bit bsy);
    logic e, f;
    e = (cnt == 0);
    f = (cnt == FIFO_DEPTH);
    return {24'd0, 4'(cnt), ovr, e, f, bsy};
  endfunction

  // Caller is at the negedge right after the edge that makes the first pop
  // possible; the frame starts on the next edge and all queued frames must
  // follow contiguously.
  task automatic checkStream(input int div, input bit intrZero);
    int n;
    int frameLen;
    logic [31:0] rd;
    n = expQ.size();
    frameLen = 10 * div;
    @(negedge clk);
    for (int f = 0; f < n; f++) begin
      for (int k = 0; k < frameLen; k++) begin
        chk("txdBit", txd, frameBit(expQ[f], k / div));
        if (intrZero) chk("intrInFrame", intr, 0);
        if (f == n - 1 && k == frameLen - 1) begin
          busRead(1, rd);
          chk("busyLastClk", rd[0], 1);
        end
        @(negedge clk);
      end
    end
    busRead(1, rd);
    chk("busyFall", rd[0], 0);
    chk("txdIdleAfter", txd, 1);
    expQ.delete();
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b, b2;
    int          n, d, eff;
    bit          ovr;

    rst = 1'b0; ioCe = 1'b0; ioWe = 1'b0; ioAddr = 32'd0; ioWtData = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstTxd", txd, 1);
    chk("rstIntr", intr, 0);
    busRead(1, rd); chk("rstStatus", rd, 32'h04);
    busRead(2, rd); chk("rstCtrl", rd, 32'h1);
    busRead(3, rd); chk("rstDiv", rd, CLK_DIV);
    busRead(0, rd); chk("txdataRead", rd, 0);
    ioAddr = 32'h4; ioCe = 1'b0; #1;
    chk("rdDataCeLow", ioRdData, 0);

    // Single frame 0xA5 at DIV=4
    @(negedge clk);
    busWrite(3, 4);
    busRead(3, rd); chk("divWrite", rd, 4);
    busWrite(0, 32'hFFFF_FFA5);
    chk("txdBeforePop", txd, 1);
    busRead(1, rd); chk("statusAfterPush", rd, statusWord(1, 0, 0));
    expQ.push_back(8'hA5);
    checkStream(4, 0);

    // Fill with tx_en=0, overrun, then contiguous burst
    busWrite(2, 0);
    ovr = 0;
    for (int i = 0; i < 9; i++) begin
      busWrite(0, i);
      if (expQ.size() < FIFO_DEPTH) expQ.push_back(8'(i));
      else ovr = 1;
    end
    busRead(1, rd); chk("fullStatus", rd, statusWord(8, ovr, 0));
    busWrite(1, 8);
    busRead(1, rd); chk("ovrCleared", rd, statusWord(8, 0, 0));
    busWrite(0, 8'h55);
    busRead(1, rd); chk("ovrSetAgain", rd, statusWord(8, 1, 0));
    busWrite(1, 8);
    busRead(1, rd); chk("ovrCleared2", rd, statusWord(8, 0, 0));
    busRead(2, rd); chk("ctrlTxOff", rd, 0);
    busWrite(2, 1);
    checkStream(4, 0);
    busRead(1, rd); chk("burstDone", rd, statusWord(0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      chk("noLostByte", txd, 1);
      @(negedge clk);
    end

    // Interrupt
    busWrite(2, 3);
    chk("intrLag", intr, 0);
    @(negedge clk);
    chk("intrRise", intr, 1);
    b = 8'($urandom());
    busWrite(0, b);
    chk("intrBeforePop", intr, 1);
    expQ.push_back(b);
    checkStream(4, 1);
    chk("intrAtBusyFall", intr, 0);
    @(negedge clk);
    chk("intrAfterFrame", intr, 1);

    // Random bursts, random divisor (0 behaves as 1)
    for (int it = 0; it < 3; it++) begin
      d = (it == 0) ? 0 : $urandom_range(1, 6);
      eff = (d == 0) ? 1 : d;
      busWrite(2, 0);
      busWrite(3, d);
      busRead(3, rd); chk("rndDiv", rd, d);
      n = $urandom_range(1, 10);
      ovr = 0;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom());
        busWrite(0, b);
        if (expQ.size() < FIFO_DEPTH) expQ.push_back(b);
        else ovr = 1;
      end
      busRead(1, rd); chk("rndStatus", rd, statusWord(expQ.size(), ovr, 0));
      busWrite(2, 1);
      checkStream(eff, 0);
      busRead(1, rd); chk("rndDone", rd, statusWord(0, ovr, 0));
      busWrite(1, 8);
    end

    // Reset in the middle of data bit 3
    busWrite(3, 4);
    b  = 8'($urandom());
    b2 = 8'($urandom());
    busWrite(0, b);
    busWrite(0, b2);
    for (int k = 0; k < 17; k++) begin
      chk("preRstTxd", txd, frameBit(b, k / 4));
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("midRstTxd", txd, 1);
    chk("midRstIntr", intr, 0);
    busRead(1, rd); chk("midRstStatus", rd, statusWord(0, 0, 0));
    rst = 1'b1;
    for (int i = 0; i < 60; i++) begin
      chk("noFrameAfterRst", txd, 1);
      @(negedge clk);
    end
    busRead(2, rd); chk("ctrlAfterRst", rd, 32'h1);
    busRead(3, rd); chk("divAfterRst", rd, CLK_DIV);
    busRead(1, rd); chk("statusAfterRst", rd, statusWord(0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
